dm_access_unit: RTL

Sub-word memory access initiator between the MEM-stage pipeline and the word-only data memory. Accepts one load/store request at a time through a valid/ready handshake and performs byte/halfword stores as read-modify-write cycles on the word interface. Extracts and sign/zero-extends load data, flags misaligned accesses, and returns one response pulse per request.

---
 rtl/dm_access_if.sv | 34 +++
 rtl/dm_access_unit.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/dm_access_if.sv
//------------------------------------------------------------------------------
// dm_access_if : request/response and word-memory signals of dm_access_unit
// Revision     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface dm_access_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_write, mem_addr, mem_wdata
    );
endinterface

`default_nettype wire

// File: rtl/dm_access_unit.sv
//------------------------------------------------------------------------------
// dm_access_unit : sub-word load/store initiator on a word-only data memory
// Revision       : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dm_access_unit (
    input  wire logic    clk,
    input  wire logic    reset,
    dm_access_if.slave   bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic        write_q, signed_q, err_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q, rword_q;
    logic [31:0] resp_rdata_q;
    logic        resp_err_q;

    logic        w_accept;
    logic        w_misalign;
    logic [7:0]  w_lane_byte;
    logic [15:0] w_lane_half;
    logic [31:0] w_load_data;
    logic [31:0] w_merge;

    assign w_accept = (state_q == S_IDLE) && bus.req_valid;

    always_comb begin
        w_misalign = 1'b0;
        case (bus.req_size)
            2'b00:   w_misalign = 1'b0;
            2'b01:   w_misalign = bus.req_addr[0];
            2'b10:   w_misalign = (bus.req_addr[1:0] != 2'b00);
            default: w_misalign = 1'b1;
        endcase
    end

    // Load lanes come straight from the word being captured at the READ edge
    always_comb begin
        w_lane_byte = bus.mem_rdata[7:0];
        case (addr_q[1:0])
            2'd0:    w_lane_byte = bus.mem_rdata[7:0];
            2'd1:    w_lane_byte = bus.mem_rdata[15:8];
            2'd2:    w_lane_byte = bus.mem_rdata[23:16];
            default: w_lane_byte = bus.mem_rdata[31:24];
        endcase
        w_lane_half = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        w_load_data = bus.mem_rdata;
        case (size_q)
            2'b00:   w_load_data = {{24{signed_q & w_lane_byte[7]}}, w_lane_byte};
            2'b01:   w_load_data = {{16{signed_q & w_lane_half[15]}}, w_lane_half};
            default: w_load_data = bus.mem_rdata;
        endcase
    end

    always_comb begin
        w_merge = rword_q;
        case (size_q)
            2'b00: begin
                case (addr_q[1:0])
                    2'd0:    w_merge[7:0]   = wdata_q[7:0];
                    2'd1:    w_merge[15:8]  = wdata_q[7:0];
                    2'd2:    w_merge[23:16] = wdata_q[7:0];
                    default: w_merge[31:24] = wdata_q[7:0];
                endcase
            end
            2'b01: begin
                if (addr_q[1]) w_merge[31:16] = wdata_q[15:0];
                else           w_merge[15:0]  = wdata_q[15:0];
            end
            default: w_merge = wdata_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_misalign)                                   state_d = S_RESP;
                    else if (bus.req_write && bus.req_size == 2'b10)  state_d = S_WRITE;
                    else                                              state_d = S_READ;
                end
            end
            S_READ:  state_d = write_q ? S_WRITE : S_RESP;
            S_WRITE: state_d = S_RESP;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            write_q      <= 1'b0;
            size_q       <= 2'b00;
            signed_q     <= 1'b0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            err_q        <= 1'b0;
            rword_q      <= 32'h0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
        end else begin
            if (w_accept) begin
                write_q  <= bus.req_write;
                size_q   <= bus.req_size;
                signed_q <= bus.req_signed;
                addr_q   <= bus.req_addr;
                wdata_q  <= bus.req_wdata;
                err_q    <= w_misalign;
            end
            if (state_q == S_READ) rword_q <= bus.mem_rdata;
            // Response registers change only on the edge entering RESP
            if (state_d == S_RESP && state_q != S_RESP) begin
                resp_rdata_q <= (state_q == S_READ && !write_q) ? w_load_data : 32'h0;
                resp_err_q   <= (state_q == S_IDLE) ? w_misalign : err_q;
            end
        end
    end

    always_comb begin
        bus.req_ready  = (state_q == S_IDLE)  && !reset;
        bus.mem_write  = (state_q == S_WRITE) && !reset;
        bus.resp_valid = (state_q == S_RESP)  && !reset;
        bus.mem_addr   = {addr_q[31:2], 2'b00};
        bus.mem_wdata  = (state_q == S_WRITE) ? w_merge : 32'h0;
        bus.resp_rdata = resp_rdata_q;
        bus.resp_err   = resp_err_q;
    end
endmodule

`default_nettype wire
